// File: rtl/eu_issue_sched.sv
// rtl/eu_issue_sched.sv - in-order two-way issue scheduler feeding an EU register buffer
module eu_issue_sched #(
    parameter int DEPTH     = 4,
    parameter int FLUSH_CYC = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       way0_valid_i,
    input  logic [1:0]                 way0_pID_i,
    output logic                       way0_ready_o,
    input  logic                       way1_valid_i,
    input  logic [1:0]                 way1_pID_i,
    output logic                       way1_ready_o,
    output logic                       eu_push_o,
    output logic                       eu_sel_o,
    input  logic                       eu_ready_i,
    output logic                       eu_pop_o,
    output logic                       eu_valid_o,
    input  logic                       jumpFlag_i,
    input  logic [1:0]                 jump_pID_i,
    output logic [$clog2(DEPTH):0]     occ_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int OW = $clog2(DEPTH) + 1;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state, state_nx;
    logic [2:0]      fcnt, fcnt_nx;
    logic [1:0]      exp_pid;
    logic            rr;
    logic            sel_q;
    logic            valid_q;
    logic [OW-1:0]   occ;
    logic            open_c;
    logic            elig0, elig1;
    logic            grant0, grant1;
    logic            tie;

    assign full_o  = (occ == OW'(DEPTH));
    assign empty_o = (occ == '0);
    assign occ_o   = occ;

    // Issue and pop are only possible in RUN, out of reset, with no redirect pending.
    assign open_c = reset_n && !jumpFlag_i && (state == RUN);
    assign elig0  = open_c && way0_valid_i && (way0_pID_i == exp_pid) && !full_o;
    assign elig1  = open_c && way1_valid_i && (way1_pID_i == exp_pid) && !full_o;
    assign tie    = elig0 && elig1;
    assign grant0 = elig0 && (!elig1 || !rr);
    assign grant1 = elig1 && (!elig0 || rr);

    assign way0_ready_o = grant0;
    assign way1_ready_o = grant1;
    assign eu_push_o    = grant0 || grant1;
    assign eu_sel_o     = grant1 ? 1'b1 : (grant0 ? 1'b0 : sel_q);
    assign eu_pop_o     = open_c && eu_ready_i && !empty_o;
    assign eu_valid_o   = valid_q;

    always_comb begin
        state_nx = state;
        fcnt_nx  = fcnt;
        if (jumpFlag_i) begin
            state_nx = FLUSH;
            fcnt_nx  = 3'(FLUSH_CYC - 1);
        end else if (state == FLUSH) begin
            if (fcnt == 3'd0) begin
                state_nx = RUN;
            end else begin
                fcnt_nx = fcnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= RUN;
            fcnt    <= 3'd0;
            exp_pid <= 2'd0;
            rr      <= 1'b0;
            occ     <= '0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state <= state_nx;
            fcnt  <= fcnt_nx;
            if (jumpFlag_i) begin
                occ     <= '0;
                exp_pid <= jump_pID_i;
                valid_q <= 1'b0;
            end else begin
                occ     <= occ + OW'(eu_push_o) - OW'(eu_pop_o);
                valid_q <= eu_pop_o;
                if (eu_push_o) begin
                    exp_pid <= exp_pid + 2'd1;
                    sel_q   <= eu_sel_o;
                end
                if (tie) begin
                    rr <= !rr;
                end
            end
        end
    end
endmodule

// File: tb/tb_eu_issue_sched.sv
// tb/tb_eu_issue_sched.sv - directed vector table plus randomized model check of eu_issue_sched
module tb_eu_issue_sched;
    localparam int DEPTH     = 4;
    localparam int FLUSH_CYC = 2;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       way0_valid_i, way1_valid_i;
    logic [1:0] way0_pID_i, way1_pID_i;
    logic       way0_ready_o, way1_ready_o;
    logic       eu_push_o, eu_sel_o, eu_ready_i, eu_pop_o, eu_valid_o;
    logic       jumpFlag_i;
    logic [1:0] jump_pID_i;
    logic [2:0] occ_o;
    logic       full_o, empty_o;

    int tests = 0;
    int fails = 0;

    eu_issue_sched #(.DEPTH(DEPTH), .FLUSH_CYC(FLUSH_CYC)) dut (
        .clk(clk), .reset_n(reset_n),
        .way0_valid_i(way0_valid_i), .way0_pID_i(way0_pID_i), .way0_ready_o(way0_ready_o),
        .way1_valid_i(way1_valid_i), .way1_pID_i(way1_pID_i), .way1_ready_o(way1_ready_o),
        .eu_push_o(eu_push_o), .eu_sel_o(eu_sel_o), .eu_ready_i(eu_ready_i),
        .eu_pop_o(eu_pop_o), .eu_valid_o(eu_valid_o),
        .jumpFlag_i(jumpFlag_i), .jump_pID_i(jump_pID_i),
        .occ_o(occ_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic rst, v0; logic [1:0] p0; logic v1; logic [1:0] p1;
        logic rdy, jmp; logic [1:0] jp;
        logic r0, r1, push, sel, pop; int occ; logic ev;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(input logic rst, v0, input logic [1:0] p0, input logic v1,
                                input logic [1:0] p1, input logic rdy, jmp, input logic [1:0] jp,
                                input logic r0, r1, push, sel, pop, input int occ, input logic ev);
        vec_t v;
        v.rst = rst; v.v0 = v0; v.p0 = p0; v.v1 = v1; v.p1 = p1;
        v.rdy = rdy; v.jmp = jmp; v.jp = jp;
        v.r0 = r0; v.r1 = r1; v.push = push; v.sel = sel; v.pop = pop; v.occ = occ; v.ev = ev;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, v0, input logic [1:0] p0, input logic v1,
                         input logic [1:0] p1, input logic rdy, jmp, input logic [1:0] jp);
        reset_n = rst; way0_valid_i = v0; way0_pID_i = p0; way1_valid_i = v1; way1_pID_i = p1;
        eu_ready_i = rdy; jumpFlag_i = jmp; jump_pID_i = jp;
    endtask

    // Reference model state: flush_left counts FLUSH cycles still to be blocked.
    int m_exp, m_occ, m_rr, m_flush, m_sel, m_valid;

    task automatic check_all(input string tag, input int idx, input int r0, r1, push, sel, pop,
                             input int occ, input int ev);
        chk({tag, ".way0_ready"}, idx, int'(way0_ready_o), r0);
        chk({tag, ".way1_ready"}, idx, int'(way1_ready_o), r1);
        chk({tag, ".push"},       idx, int'(eu_push_o),    push);
        chk({tag, ".sel"},        idx, int'(eu_sel_o),     sel);
        chk({tag, ".pop"},        idx, int'(eu_pop_o),     pop);
        chk({tag, ".occ"},        idx, int'(occ_o),        occ);
        chk({tag, ".full"},       idx, int'(full_o),       int'(occ == DEPTH));
        chk({tag, ".empty"},      idx, int'(empty_o),      int'(occ == 0));
        chk({tag, ".valid"},      idx, int'(eu_valid_o),   ev);
    endtask

    initial begin
        tbl[0]  = mk(0,1,0,0,0,1,0,0, 0,0,0,0,0,0,0);
        tbl[1]  = mk(1,1,1,1,0,0,0,0, 0,1,1,1,0,0,0);
        tbl[2]  = mk(1,1,1,0,0,0,0,0, 1,0,1,0,0,1,0);
        tbl[3]  = mk(1,1,2,1,2,1,0,0, 1,0,1,0,1,2,0);
        tbl[4]  = mk(1,1,3,1,3,0,0,0, 0,1,1,1,0,2,1);
        tbl[5]  = mk(1,1,0,0,0,0,0,0, 1,0,1,0,0,3,0);
        tbl[6]  = mk(1,1,1,1,1,1,0,0, 0,0,0,0,1,4,0);
        tbl[7]  = mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,3,1);
        tbl[8]  = mk(1,1,1,0,0,1,1,2, 0,0,0,0,0,3,0);
        tbl[9]  = mk(1,1,2,0,0,1,0,0, 0,0,0,0,0,0,0);
        tbl[10] = mk(1,0,0,1,2,0,0,0, 0,0,0,0,0,0,0);
        tbl[11] = mk(1,0,0,1,2,0,0,0, 0,1,1,1,0,0,0);
        tbl[12] = mk(1,0,0,0,0,0,1,1, 0,0,0,1,0,1,0);
        tbl[13] = mk(1,0,0,0,0,0,1,3, 0,0,0,1,0,0,0);
        tbl[14] = mk(1,1,3,0,0,0,0,0, 0,0,0,1,0,0,0);
        tbl[15] = mk(1,1,3,0,0,0,0,0, 0,0,0,1,0,0,0);
        tbl[16] = mk(1,1,3,0,0,0,0,0, 1,0,1,0,0,0,0);
        tbl[17] = mk(1,0,0,0,0,0,1,2, 0,0,0,0,0,1,0);
        tbl[18] = mk(0,1,0,0,0,1,0,0, 0,0,0,0,0,0,0);
        tbl[19] = mk(1,1,0,1,2,0,0,0, 1,0,1,0,0,0,0);
        tbl[20] = mk(1,0,0,0,0,1,0,0, 0,0,0,0,1,1,0);
        tbl[21] = mk(1,0,0,0,0,1,0,0, 0,0,0,0,0,0,1);
        tbl[22] = mk(1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);

        drive(0,0,0,0,0,0,0,0);
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst, tbl[i].v0, tbl[i].p0, tbl[i].v1, tbl[i].p1,
                  tbl[i].rdy, tbl[i].jmp, tbl[i].jp);
            #1;
            check_all("vec", i, tbl[i].r0, tbl[i].r1, tbl[i].push, tbl[i].sel, tbl[i].pop,
                      tbl[i].occ, tbl[i].ev);
            @(posedge clk);
            #1;
        end

        for (int c = 0; c < 3000; c++) begin
            logic rst, v0, v1, rdy, jmp;
            logic [1:0] p0, p1, jp;
            int e0, e1, g, pop, sel;
            bit blocked;
            rst = (c == 0) ? 1'b0 : ($urandom_range(0, 63) != 0);
            jmp = ($urandom_range(0, 15) == 0);
            jp  = 2'($urandom_range(0, 3));
            v0  = ($urandom_range(0, 3) != 0);
            v1  = ($urandom_range(0, 3) != 0);
            p0  = $urandom_range(0, 1) ? 2'(m_exp) : 2'($urandom_range(0, 3));
            p1  = $urandom_range(0, 1) ? 2'(m_exp) : 2'($urandom_range(0, 3));
            rdy = ($urandom_range(0, 2) == 0);
            drive(rst, v0, p0, v1, p1, rdy, jmp, jp);

            blocked = !rst || jmp || (m_flush > 0);
            e0 = (!blocked && v0 && int'(p0) == m_exp && m_occ < DEPTH) ? 1 : 0;
            e1 = (!blocked && v1 && int'(p1) == m_exp && m_occ < DEPTH) ? 1 : 0;
            if (e0 && e1) g = m_rr;
            else if (e0)  g = 0;
            else if (e1)  g = 1;
            else          g = -1;
            pop = (!blocked && rdy && m_occ > 0) ? 1 : 0;
            sel = (g >= 0) ? g : m_sel;

            #1;
            if (c > 0) begin
                check_all("rnd", c, int'(g == 0), int'(g == 1), int'(g >= 0), sel, pop,
                          m_occ, m_valid);
            end

            if (!rst) begin
                m_exp = 0; m_occ = 0; m_rr = 0; m_flush = 0; m_sel = 0; m_valid = 0;
            end else if (jmp) begin
                m_occ = 0; m_exp = int'(jp); m_flush = FLUSH_CYC; m_valid = 0;
            end else begin
                if (m_flush > 0) m_flush--;
                m_occ = m_occ + int'(g >= 0) - pop;
                m_valid = pop;
                if (g >= 0) begin
                    m_exp = (m_exp + 1) % 4;
                    m_sel = g;
                end
                if (e0 && e1) m_rr = 1 - m_rr;
            end
            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/eu_issue_sched.md
EU_ISSUE_SCHED -- requirements
Module: eu_issue_sched

Interface
REQ-001 Parameter DEPTH, default 4, SHALL be the entry count of the downstream EU register buffer (power of two, 2..16).
REQ-002 Parameter FLUSH_CYC, default 2, SHALL be the number of cycles issue is blocked after a jump (1..7).
REQ-003 Ports SHALL be, in order:
- clk  in  1  single clock, rising edge.
- reset_n  in  1  reset; synchronous and active-low.
- way0_valid_i  in  1  way0 has an instruction to issue.
- way0_pID_i  in  2  way0 program-order ID.
- way0_ready_o  out  1  way0 granted this cycle.
- way1_valid_i  in  1  way1 has an instruction to issue.
- way1_pID_i  in  2  way1 program-order ID.
- way1_ready_o  out  1  way1 granted this cycle.
- eu_push_o  out  1  write strobe (WInc) into the EU buffer.
- eu_sel_o  out  1  datapath mux select: 0 = way0, 1 = way1.
- eu_ready_i  in  1  EU consumer requests a pop.
- eu_pop_o  out  1  read strobe (RInc) into the EU buffer.
- eu_valid_o  out  1  registered "entry delivered" pulse.
- jumpFlag_i  in  1  redirect; flush everything queued.
- jump_pID_i  in  2  first pID on the new path.
- occ_o  out  $clog2(DEPTH)+1  current buffer occupancy.
- full_o / empty_o  out  1 each  occ_o==DEPTH / occ_o==0.

Function
REQ-004 The FSM SHALL have two states: RUN and FLUSH.
REQ-005 The expected pID register exp_pid SHALL name the only pID allowed to issue next.
REQ-006 In RUN, wayN is eligible when wayN_valid_i=1, wayN_pID_i==exp_pid and full_o=0.
REQ-007 At most one grant per cycle SHALL be made.
REQ-008 If both ways are eligible, the grant SHALL go to the way indicated by a round-robin pointer rr; rr SHALL toggle to the other way after each such tie.
REQ-009 If only one way is eligible, it SHALL be granted and rr SHALL be unchanged.
REQ-010 Grant outputs (wayN_ready_o, eu_push_o, eu_sel_o) SHALL be combinational in the same cycle.
REQ-011 When no grant is made, eu_push_o=0 and eu_sel_o SHALL hold its last value.
REQ-012 On a grant, exp_pid SHALL increment mod 4 at the next edge (3 wraps to 0).
REQ-013 eu_pop_o SHALL equal eu_ready_i && !empty_o, combinationally.
REQ-014 eu_valid_o SHALL be registered eu_pop_o (one-cycle latency).
REQ-015 occ_o SHALL update next edge by +push -pop.
- A simultaneous push and pop SHALL leave occ_o unchanged.
- A full buffer blocks push even when a pop occurs in the same cycle (no pass-through).
REQ-016 When jumpFlag_i=1 in any state:
- No grant and no pop that cycle.
- Next edge: occ_o<=0, exp_pid<=jump_pID_i, state<=FLUSH, flush counter<=FLUSH_CYC-1, eu_valid_o<=0.
REQ-017 In FLUSH, all grants and pops SHALL be blocked; the counter decrements each cycle; state returns to RUN on the edge where the counter is 0.
REQ-018 A jumpFlag_i arriving during FLUSH SHALL reload the counter and exp_pid.

Reset
REQ-019 When reset_n=0 at a rising edge, the following SHALL be set: state=RUN, exp_pid=0, rr=way0, occ_o=0, eu_valid_o=0, eu_sel_o=0, flush counter=0.
REQ-020 Reset SHALL take priority over jumpFlag_i and all handshakes, including mid-FLUSH.
REQ-021 While reset_n=0, all combinational grant and pop outputs SHALL be 0.

Verification
REQ-022 In-order issue: exp_pid=0, way0 pID=1 and way1 pID=0 both valid -> way1 granted, eu_sel_o=1; next cycle way0 granted; exp_pid=2.
REQ-023 Full boundary, DEPTH=4: 4 grants with no pops -> occ_o=4, full_o=1, ready outputs 0. Then eu_ready_i=1 with a valid way -> pop only, occ_o=3, eu_valid_o=1 one cycle later.
REQ-024 Simultaneous push and pop at occ_o=2 -> occ_o stays 2. At occ_o=0 with eu_ready_i=1 -> eu_pop_o=0.
REQ-025 Jump: occ_o=3, jumpFlag_i=1, jump_pID_i=2 -> next cycle occ_o=0 and FSM in FLUSH for 2 cycles with no grants. The first grant after that is to the way presenting pID 2.
REQ-026 Tie and wrap: both ways present pID 3 with exp_pid=3 -> rr winner granted, rr toggles, exp_pid wraps to 0.
REQ-027 Reset mid-FLUSH: reset_n=0 for 1 cycle -> state RUN, exp_pid=0 and occ_o=0 next cycle; the first grant goes to pID 0.
